ram_dma_ci: RTL and testbench
=============================

# ram_dma_ci

Custom-instruction slave giving the CPU access to a 512 × 32-bit local scratch memory and to the DMA configuration registers: bus start address, memory start address, block size and burst size. It decodes one custom-instruction opcode, selected by parameter `customId`. It completes either combinationally, in the same cycle, or with one cycle of latency for memory reads. It sits on the processor's custom-instruction port and provides the register and memory front end for a DMA engine.

## Interface
Parameters:
- `customId`, default 8'd0: custom-instruction number this block responds to.

Ports:
- `clock`  in  1  system clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  custom-instruction start strobe, one cycle wide.
- `ciN`  in  8  custom-instruction number; the block acts only when `start`=1 and `ciN`==`customId`.
- `valueA`  in  32  command word:
  - [8:0] memory address;
  - [9] write enable;
  - [12:10] register select;
  - [31:13] ignored.
- `valueB`  in  32  write data.
- `done`  out  1  completion strobe.
- `result`  out  32  read data; 0 whenever `done`=0.

## Operation
- Define `sel` = `start` && (`ciN`==`customId`) && !`pending`.
- `sel` is 0 when the strobe is inactive, when `ciN` mismatches, or when a read is pending. In that case there is no state change, and `done`/`result` are 0 unless a pending read completes.
- Register select 000, memory:
  - Write (bit9=1): mem[valueA[8:0]] ← valueB on the clock edge. `done`=1 and `result`=0 in the same cycle.
  - Read (bit9=0): the memory is a synchronous read. Set `pending` on the edge. The start cycle has `done`=0 and `result`=0. The next cycle has `done`=1 and `result`=mem[addr].
- Register select 001: bus start address, 32 bits.
- Register select 010: memory start address, 9 bits.
- Register select 011: block size, 10 bits.
- Register select 100: burst size, 8 bits.
- Configuration registers 001–100:
  - Write (bit9=1): the register ← the low bits of `valueB`; higher bits are discarded. `done`=1 and `result`=0 combinationally.
  - Read (bit9=0): `done`=1 and `result`=register value, zero-extended, combinationally.
- Register selects 101–111: reserved. Writes are ignored; `done`=1 and `result`=0 combinationally.
- A `start` that arrives while `pending`=1 is ignored. The CPU never issues one, because it waits for `done`.
- A write followed by a read of the same address on the next cycle returns the new data.

## Timing
- Reset (`reset`=0):
  - configuration registers clear to 0 and `pending` clears to 0 immediately;
  - `done`=0 and `result`=0 while reset is held;
  - memory contents are not reset.
- Reset asserted while a read is pending: the read is dropped and no `done` is produced.
- Latency:
  - writes, configuration reads and reserved selects: 0 cycles, with `done` in the same cycle as `start`;
  - memory reads: 1 cycle.
- `done` is high for exactly one cycle per accepted instruction.
- `result` is registered only for memory reads. For configuration reads it is a combinational mux.
- Back-to-back operation: a new instruction may start in the cycle after a read's `done` cycle. Writes may issue on every cycle.

## Configuration
- `RAMDMACI_CONFIG_READBACK_EN` defined: configuration-register reads return the register value as specified above.
- `RAMDMACI_CONFIG_READBACK_EN` undefined:
  - configuration-register reads still complete with `done`=1 in the same cycle, but `result`=0;
  - the registers remain writable.
- Memory reads are unaffected by the macro.

## Test plan
- Activation:
  - start=0, ciN=14 gives done=0, result=0;
  - start=1, ciN=7 with customId=14 gives done=0, result=0.
- Memory at address 0:
  - write valueA=0x200, valueB=0x42 gives done=1, result=0 in the same cycle;
  - read valueA=0x000 gives done=0 in the start cycle, then done=1, result=0x42 in the next cycle.
- Memory at address 0x37: write 0x237/0x57, then read 0x037 gives result 0x57 after 1 cycle.
- Configuration round trip, each write and read returning done=1 in the same cycle:
  - write 0x600/0x29, then read 0x400, gives 0x29;
  - the same pattern on 0xA00/0x800 returns 0x15;
  - on 0xE00/0xC00 it returns 0x34;
  - on 0x1200/0x1000 it returns 0x16.
- Width truncation: write memory start address (0xA00) with valueB=0xFFFF_FFFF; reading 0x800 returns 0x1FF.
- Reset mid-read: issue a read at 0x037, then assert reset before the next edge. done stays 0, and reading bus start address afterwards returns 0.

Source files
------------

// File: rtl/ram_dma_ci.sv
// Custom-instruction front end for a DMA engine: 512x32 scratch memory plus DMA config registers.
// Optional macro RAMDMACI_CONFIG_READBACK_EN: when defined, config-register reads return their value.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | ready to accept a custom instruction
// ST_RD   | memory read issued, data presented this cycle

module ram_dma_ci #(
  parameter logic [7:0] customId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic {ST_IDLE, ST_RD} state_t;

  state_t      state_q, state_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [8:0]  mem_start_q, mem_start_d;
  logic [9:0]  blk_size_q, blk_size_d;
  logic [7:0]  burst_q, burst_d;

  logic [31:0] mem_q [512];
  logic [31:0] rd_data_q;

  logic [8:0]  addr;
  logic        wr_en;
  logic [2:0]  rsel;
  logic        sel;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] cfg_rd_data;

  assign addr  = valueA[8:0];
  assign wr_en = valueA[9];
  assign rsel  = valueA[12:10];

  // reset gates acceptance so nothing completes while reset is held
  assign sel    = reset && start && (ciN == customId) && (state_q == ST_IDLE);
  assign mem_wr = sel && (rsel == 3'd0) && wr_en;
  assign mem_rd = sel && (rsel == 3'd0) && !wr_en;

  always_comb begin
    bus_addr_d  = bus_addr_q;
    mem_start_d = mem_start_q;
    blk_size_d  = blk_size_q;
    burst_d     = burst_q;
    state_d     = mem_rd ? ST_RD : ST_IDLE;
    if (sel && wr_en) begin
      case (rsel)
        3'd1:    bus_addr_d  = valueB;
        3'd2:    mem_start_d = valueB[8:0];
        3'd3:    blk_size_d  = valueB[9:0];
        3'd4:    burst_d     = valueB[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bus_addr_q  <= '0;
      mem_start_q <= '0;
      blk_size_q  <= '0;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      mem_start_q <= mem_start_d;
      blk_size_q  <= blk_size_d;
      burst_q     <= burst_d;
    end
  end

  // memory contents and read register are intentionally not reset
  always_ff @(posedge clock) begin
    if (mem_wr) mem_q[addr] <= valueB;
    if (mem_rd) rd_data_q <= mem_q[addr];
  end

`ifdef RAMDMACI_CONFIG_READBACK_EN
  logic unused_bits;
  assign unused_bits = ^valueA[31:13];

  always_comb begin
    cfg_rd_data = '0;
    case (rsel)
      3'd1:    cfg_rd_data = bus_addr_q;
      3'd2:    cfg_rd_data = {23'd0, mem_start_q};
      3'd3:    cfg_rd_data = {22'd0, blk_size_q};
      3'd4:    cfg_rd_data = {24'd0, burst_q};
      default: cfg_rd_data = '0;
    endcase
  end
`else
  logic unused_bits;
  assign unused_bits = ^{valueA[31:13], bus_addr_q, mem_start_q, blk_size_q, burst_q};
  assign cfg_rd_data = '0;
`endif

  always_comb begin
    done   = (state_q == ST_RD) || (sel && !mem_rd);
    result = '0;
    if (state_q == ST_RD)      result = rd_data_q;
    else if (sel && !wr_en)    result = cfg_rd_data;
  end

endmodule

// File: tb/tb_ram_dma_ci.sv
// Scoreboard bench for ram_dma_ci: driver pushes expected completions, negedge monitor pops and compares.
// Reference model: plain arrays and registers updated from the instruction semantics.

module tb_ram_dma_ci;

  localparam logic [7:0] CID = 8'd14;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  ram_dma_ci #(.customId(CID)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .ciN   (ciN),
    .valueA(valueA),
    .valueB(valueB),
    .done  (done),
    .result(result)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_mem [512];
  logic [31:0] m_bus;
  logic [8:0]  m_mst;
  logic [9:0]  m_blk;
  logic [7:0]  m_bur;
  bit          pend_next;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  function automatic logic [31:0] cfg_val(input logic [2:0] r);
    logic [31:0] v;
    case (r)
      3'd1:    v = m_bus;
      3'd2:    v = {23'd0, m_mst};
      3'd3:    v = {22'd0, m_blk};
      3'd4:    v = {24'd0, m_bur};
      default: v = 32'd0;
    endcase
`ifndef RAMDMACI_CONFIG_READBACK_EN
    v = 32'd0;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_bus = 0; m_mst = 0; m_blk = 0; m_bur = 0;
    pend_next = 0;
  endtask

  task automatic drive(input bit st, input logic [7:0] ci, input logic [31:0] a, input logic [31:0] b);
    bit          acc;
    logic [2:0]  r;
    exp_t        e;
    @(posedge clock);
    #1;
    start = st; ciN = ci; valueA = a; valueB = b;
    acc = st && (ci == CID) && !pend_next && (reset == 1'b1);
    pend_next = 0;
    r = a[12:10];
    if (acc) begin
      if (r == 3'd0 && !a[9]) begin
        e.cyc = cyc + 1; e.data = m_mem[a[8:0]];
        q.push_back(e);
        pend_next = 1;
      end else begin
        e.cyc = cyc; e.data = a[9] ? 32'd0 : cfg_val(r);
        q.push_back(e);
        if (a[9]) begin
          case (r)
            3'd0:    m_mem[a[8:0]] = b;
            3'd1:    m_bus = b;
            3'd2:    m_mst = b[8:0];
            3'd3:    m_blk = b[9:0];
            3'd4:    m_bur = b[7:0];
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, CID, 32'd0, 32'd0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (done === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d result=%h required no done", cyc, result);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || result !== e.data) begin
          errors++;
          $display("FAIL completion cyc=%0d result=%h required cyc=%0d result=%h", cyc, result, e.cyc, e.data);
        end
      end
    end else begin
      checks++;
      if (done !== 1'b0 || result !== 32'd0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d done=%b result=%h required done=0 result=0", cyc, done, result);
      end
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_done cyc=%0d done=0 required done=1 result=%h", cyc, e.data);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  ci;
    bit          st;

    reset = 1'b0; start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // activation: no strobe, then wrong ciN
    drive(1'b0, CID, 32'h200, 32'h99);
    drive(1'b1, 8'd7, 32'h200, 32'h99);
    idle();

    // config registers read zero after reset
    for (int r = 1; r <= 4; r++) drive(1'b1, CID, 32'(r) << 10, 32'd0);

    // fill memory so every later read has defined data
    for (int i = 0; i < 512; i++) drive(1'b1, CID, 32'h200 | 32'(i), $urandom);

    // directed memory cases
    drive(1'b1, CID, 32'h200, 32'h42);
    drive(1'b1, CID, 32'h000, 32'h0);
    idle();
    drive(1'b1, CID, 32'h237, 32'h57);
    drive(1'b1, CID, 32'h037, 32'h0);
    drive(1'b1, CID, 32'h237, 32'hDEAD);   // arrives while pending, must be ignored
    drive(1'b1, CID, 32'h037, 32'h0);
    idle();

    // config round trips and truncation
    drive(1'b1, CID, 32'h600, 32'h29);   drive(1'b1, CID, 32'h400, 32'h0);
    drive(1'b1, CID, 32'hA00, 32'h15);   drive(1'b1, CID, 32'h800, 32'h0);
    drive(1'b1, CID, 32'hE00, 32'h34);   drive(1'b1, CID, 32'hC00, 32'h0);
    drive(1'b1, CID, 32'h1200, 32'h16);  drive(1'b1, CID, 32'h1000, 32'h0);
    drive(1'b1, CID, 32'hA00, 32'hFFFF_FFFF); drive(1'b1, CID, 32'h800, 32'h0);
    drive(1'b1, CID, 32'hE00, 32'hFFFF_FFFF); drive(1'b1, CID, 32'hC00, 32'h0);
    drive(1'b1, CID, 32'h1200, 32'hFFFF_FFFF); drive(1'b1, CID, 32'h1000, 32'h0);
    drive(1'b1, CID, 32'h1E00, 32'h77);  drive(1'b1, CID, 32'h1C00, 32'h0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      st = ($urandom_range(0, 9) != 0);
      ci = ($urandom_range(0, 7) == 0) ? 8'($urandom) : CID;
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[12:10] = 3'd0;
      if ($urandom_range(0, 1) == 0) a[8:0] = 9'($urandom_range(0, 15));
      b  = $urandom;
      drive(st, ci, a, b);
    end
    idle();

    // reset asserted before the edge that would register the read
    drive(1'b1, CID, 32'h037, 32'h0);
    void'(q.pop_back());
    #2 reset = 1'b0; start = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    drive(1'b1, CID, 32'h400, 32'h0);
    drive(1'b1, CID, 32'h037, 32'h0);
    idle();

    // reset asserted while the read is pending
    drive(1'b1, CID, 32'h600, 32'hCAFE_F00D);
    drive(1'b1, CID, 32'h010, 32'h0);
    void'(q.pop_back());
    @(posedge clock);
    #2 reset = 1'b0; start = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    drive(1'b1, CID, 32'h400, 32'h0);
    drive(1'b1, CID, 32'h010, 32'h0);
    repeat (3) idle();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
